// File: rtl/img_proc_pkg.sv
// Shared constants, state encodings and length helpers
// for the row-buffer scheduler.
package img_proc_pkg;

  localparam int NUM_SLOTS     = 4;
  localparam int PTR_W         = 2;
  localparam int OCC_W         = PTR_W + 1;
  localparam int LEN_W         = 12;
  localparam int MAX_ROW_BYTES = 2820;
  localparam int KERNEL_DIM    = 3;
  localparam int BYTES_PER_PX  = 3;
  localparam int EDGE_BYTES    = BYTES_PER_PX * (KERNEL_DIM - 1);

  typedef enum logic {
    RX_IDLE   = 1'b0,
    RX_ACTIVE = 1'b1
  } rx_state_t;

  typedef enum logic [1:0] {
    P_IDLE  = 2'd0,
    P_RUN   = 2'd1,
    P_FLUSH = 2'd2
  } p_state_t;

  function automatic logic len_bad(
    input logic [LEN_W-1:0] len
  );
    return (len <= LEN_W'(EDGE_BYTES)) ||
           (len >  LEN_W'(MAX_ROW_BYTES));
  endfunction

  // Kernel output loses one pixel's worth of bytes at each side.
  function automatic logic [LEN_W-1:0] out_len(
    input logic [LEN_W-1:0] len
  );
    return len_bad(len) ? '0 : len - LEN_W'(EDGE_BYTES);
  endfunction

endpackage

// File: rtl/slot_occupancy_ctr.sv
// Saturating count of completed rows in the buffer;
// simultaneous inc and dec cancel.
module slot_occupancy_ctr
  import img_proc_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [OCC_W-1:0] occ
);

  logic full;
  logic empty;

  assign full  = occ == OCC_W'(NUM_SLOTS);
  assign empty = occ == '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      occ <= '0;
    end else if (clr) begin
      occ <= '0;
    end else if (inc && !dec && !full) begin
      occ <= occ + 1'b1;
    end else if (dec && !inc && !empty) begin
      occ <= occ - 1'b1;
    end
  end

endmodule

// File: rtl/row_window_sched.sv
// Slot sequencer for the rotating row buffer feeding
// the 3x3 kernel: rx slot grants, windows, frame flush.
module row_window_sched
  import img_proc_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             rx_start,
  input  logic             rx_done,
  input  logic [LEN_W-1:0] rx_len,
  input  logic             frame_end,
  input  logic             proc_done,
  output logic             rx_grant,
  output logic [PTR_W-1:0] wr_slot,
  output logic             proc_start,
  output logic [PTR_W-1:0] win_top,
  output logic [PTR_W-1:0] win_mid,
  output logic [PTR_W-1:0] win_bot,
  output logic [LEN_W-1:0] proc_len,
  output logic [OCC_W-1:0] occ,
  output logic             busy,
  output logic             frame_done,
  output logic             err_len
);

  rx_state_t        rx_state;
  rx_state_t        rx_next;
  p_state_t         p_state;
  p_state_t         p_next;
  logic [PTR_W-1:0] rd_slot;
  logic [LEN_W-1:0] frame_len;
  logic             len_valid;
  logic             end_pend;
  logic             live;
  logic             flush;
  logic             row_acc;
  logic             pass_done;
  logic             room;

  assign flush     = p_state == P_FLUSH;
  assign row_acc   = (rx_state == RX_ACTIVE) && rx_done;
  assign pass_done = (p_state == P_RUN) && proc_done;
  assign room      = occ < OCC_W'(NUM_SLOTS);

  // Grant stays low until the first cycle after reset release.
  assign rx_grant = live && (rx_state == RX_IDLE) &&
                    room && !end_pend && !flush;

  assign win_top  = rd_slot;
  assign win_mid  = rd_slot + PTR_W'(1);
  assign win_bot  = rd_slot + PTR_W'(2);
  assign proc_len = out_len(frame_len);
  assign busy     = p_state != P_IDLE;

  slot_occupancy_ctr u_occ (
    .clock (clock),
    .reset (reset),
    .inc   (row_acc),
    .dec   (pass_done),
    .clr   (flush),
    .occ   (occ)
  );

  always_comb begin
    rx_next = rx_state;
    unique case (rx_state)
      RX_IDLE: begin
        if (rx_start && rx_grant) rx_next = RX_ACTIVE;
      end
      RX_ACTIVE: begin
        if (rx_done) rx_next = RX_IDLE;
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  // An in-flight row must land before the frame flushes.
  always_comb begin
    p_next = p_state;
    unique case (p_state)
      P_IDLE: begin
        if (occ >= OCC_W'(KERNEL_DIM)) begin
          p_next = P_RUN;
        end else if (end_pend && rx_state == RX_IDLE) begin
          p_next = P_FLUSH;
        end
      end
      P_RUN: begin
        if (proc_done) p_next = P_IDLE;
      end
      P_FLUSH: p_next = P_IDLE;
      default: p_next = P_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_state   <= RX_IDLE;
      p_state    <= P_IDLE;
      live       <= 1'b0;
      proc_start <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      rx_state   <= rx_next;
      p_state    <= p_next;
      live       <= 1'b1;
      proc_start <= (p_state == P_IDLE) &&
                    (p_next == P_RUN);
      frame_done <= flush;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_slot <= '0;
      rd_slot <= '0;
    end else begin
      if (row_acc) wr_slot <= wr_slot + 1'b1;
      if (flush) begin
        rd_slot <= wr_slot;
      end else if (pass_done) begin
        rd_slot <= rd_slot + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      end_pend <= 1'b0;
    end else if (flush) begin
      end_pend <= 1'b0;
    end else if (frame_end) begin
      end_pend <= 1'b1;
    end
  end

  // First row of a frame sets the reference length.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frame_len <= '0;
      len_valid <= 1'b0;
      err_len   <= 1'b0;
    end else begin
      if (flush) begin
        frame_len <= '0;
        len_valid <= 1'b0;
      end else if (row_acc && !len_valid) begin
        frame_len <= rx_len;
        len_valid <= 1'b1;
      end
      if (row_acc) begin
        if (len_valid ? (rx_len != frame_len)
                      : len_bad(rx_len)) begin
          err_len <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_row_window_sched.sv
// Directed + randomized bench for row_window_sched
// against a queue-free slot/row reference model.
module tb_row_window_sched;
  import img_proc_pkg::*;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             rx_start = 1'b0;
  logic             rx_done = 1'b0;
  logic [LEN_W-1:0] rx_len = '0;
  logic             frame_end = 1'b0;
  logic             proc_done = 1'b0;
  logic             rx_grant;
  logic [PTR_W-1:0] wr_slot;
  logic             proc_start;
  logic [PTR_W-1:0] win_top;
  logic [PTR_W-1:0] win_mid;
  logic [PTR_W-1:0] win_bot;
  logic [LEN_W-1:0] proc_len;
  logic [OCC_W-1:0] occ;
  logic             busy;
  logic             frame_done;
  logic             err_len;

  int errors = 0;
  int checks = 0;
  int n_start = 0;

  int m_wr = 0;
  int m_rd = 0;
  int m_occ = 0;
  int m_starts = 0;
  int m_len = 0;
  bit m_run = 0;
  bit m_have = 0;
  bit m_err = 0;

  always #5 clock = ~clock;

  row_window_sched dut (
    .clock      (clock),
    .reset      (reset),
    .rx_start   (rx_start),
    .rx_done    (rx_done),
    .rx_len     (rx_len),
    .frame_end  (frame_end),
    .proc_done  (proc_done),
    .rx_grant   (rx_grant),
    .wr_slot    (wr_slot),
    .proc_start (proc_start),
    .win_top    (win_top),
    .win_mid    (win_mid),
    .win_bot    (win_bot),
    .proc_len   (proc_len),
    .occ        (occ),
    .busy       (busy),
    .frame_done (frame_done),
    .err_len    (err_len)
  );

  always @(negedge clock) if (proc_start === 1'b1) n_start++;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_plen();
    if (!m_have || m_len <= 6 || m_len > 2820) return 0;
    return m_len - 6;
  endfunction

  task automatic model_eval();
    if (!m_run && m_occ >= 3) begin
      m_run = 1;
      m_starts++;
    end
  endtask

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_occ = 0; m_run = 0;
    m_have = 0; m_len = 0; m_err = 0;
  endtask

  task automatic send_row(input int len,
                          input bit with_pd,
                          input bit fe_mid);
    int n = 0;
    while (rx_grant !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("grant_wait", rx_grant, 1);
    chk("wr_slot", wr_slot, m_wr);
    if (m_run)
      chk("no_overlap", (wr_slot == win_top) ||
          (wr_slot == win_mid) || (wr_slot == win_bot), 0);
    rx_start = 1; tick(); rx_start = 0;
    chk("grant_drop", rx_grant, 0);
    repeat ($urandom_range(0, 2)) tick();
    if (fe_mid) begin
      frame_end = 1; tick(); frame_end = 0;
    end
    rx_len = LEN_W'(len);
    rx_done = 1;
    proc_done = with_pd;
    tick();
    rx_done = 0;
    proc_done = 0;
    if (!m_have) begin
      m_have = 1;
      m_len = len;
      if (len <= 6 || len > 2820) m_err = 1;
    end else if (len != m_len) begin
      m_err = 1;
    end
    m_wr = (m_wr + 1) % 4;
    m_occ++;
    if (with_pd) begin
      m_occ--;
      m_rd = (m_rd + 1) % 4;
      m_run = 0;
    end
    model_eval();
    chk("occ_row", occ, m_occ);
    chk("err_len", err_len, m_err);
  endtask

  task automatic finish_pass();
    int n = 0;
    while (busy !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("busy", busy, 1);
    tick();
    chk("starts", n_start, m_starts);
    chk("win_top", win_top, m_rd);
    chk("win_mid", win_mid, (m_rd + 1) % 4);
    chk("win_bot", win_bot, (m_rd + 2) % 4);
    chk("proc_len", proc_len, exp_plen());
    repeat ($urandom_range(0, 3)) tick();
    chk("win_stable", win_top, m_rd);
    proc_done = 1; tick(); proc_done = 0;
    m_occ--;
    m_rd = (m_rd + 1) % 4;
    m_run = 0;
    model_eval();
    chk("occ_pass", occ, m_occ);
  endtask

  task automatic wait_frame_done();
    int n = 0;
    bit seen = 0;
    while (!seen && n < 20) begin
      if (frame_done === 1'b1) seen = 1;
      else begin
        tick();
        n++;
      end
    end
    chk("frame_done", seen, 1);
    m_occ = 0; m_rd = m_wr; m_have = 0; m_len = 0;
    tick();
    chk("fd_pulse", frame_done, 0);
    chk("occ_flush", occ, 0);
    chk("rd_flush", win_top, m_rd);
    chk("grant_resume", rx_grant, 1);
    chk("starts_flush", n_start, m_starts);
  endtask

  task automatic chk_reset_vals();
    chk("rst_grant", rx_grant, 0);
    chk("rst_wr", wr_slot, 0);
    chk("rst_top", win_top, 0);
    chk("rst_mid", win_mid, 1);
    chk("rst_bot", win_bot, 2);
    chk("rst_pstart", proc_start, 0);
    chk("rst_plen", proc_len, 0);
    chk("rst_occ", occ, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fdone", frame_done, 0);
    chk("rst_err", err_len, 0);
  endtask

  initial begin
    int lens[3];
    int l;
    repeat (2) tick();
    chk_reset_vals();
    @(negedge clock) reset = 1;
    tick();

    for (int i = 0; i < 3; i++) send_row(30, 0, 0);
    tick();
    chk("pstart_lat", proc_start, 1);
    chk("busy_run", busy, 1);
    tick();
    chk("pstart_pulse", proc_start, 0);
    chk("t1_top", win_top, 0);
    chk("t1_bot", win_bot, 2);
    chk("t1_plen", proc_len, 24);
    chk("t1_occ", occ, 3);

    send_row(30, 0, 0);
    tick();
    chk("full_nogrant", rx_grant, 0);
    rx_start = 1; tick(); rx_start = 0; tick();
    chk("ign_start_grant", rx_grant, 0);
    chk("ign_start_wr", wr_slot, m_wr);
    rx_done = 1; tick(); rx_done = 0;
    chk("ign_done_occ", occ, m_occ);
    finish_pass();

    for (int i = 0; i < 3; i++) begin
      send_row(30, 0, 0);
      finish_pass();
    end

    send_row(30, 1, 0);
    finish_pass();

    frame_end = 1; tick(); frame_end = 0;
    wait_frame_done();
    proc_done = 1; tick(); proc_done = 0;
    chk("ign_pdone_occ", occ, 0);
    chk("ign_pdone_rd", win_top, m_rd);

    l = $urandom_range(7, 2820);
    send_row(l, 0, 0);
    send_row(l, 0, 1);
    wait_frame_done();

    lens[0] = 7;
    lens[1] = $urandom_range(7, 2820);
    lens[2] = 2820;
    foreach (lens[k]) begin
      for (int i = 0; i < 3; i++) send_row(lens[k], 0, 0);
      finish_pass();
      frame_end = 1; tick(); frame_end = 0;
      wait_frame_done();
    end

    send_row(5, 0, 0);
    chk("short_plen", proc_len, 0);
    frame_end = 1; tick(); frame_end = 0;
    wait_frame_done();

    for (int i = 0; i < 3; i++) send_row(30, 0, 0);
    for (int n = 0; n < 20 && busy !== 1'b1; n++) tick();
    chk("pre_rst_busy", busy, 1);
    for (int n = 0; n < 20 && rx_grant !== 1'b1; n++) tick();
    rx_start = 1; tick(); rx_start = 0;
    chk("pre_rst_active", rx_grant, 0);
    @(posedge clock);
    #3 reset = 0;
    #1 chk_reset_vals();
    model_reset();
    @(negedge clock) reset = 1;
    tick();

    send_row(30, 0, 0);
    send_row(31, 0, 0);
    chk("mism_plen", proc_len, exp_plen());
    frame_end = 1; tick(); frame_end = 0;
    wait_frame_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
